// File: rtl/mem_arbiter_if.sv
// Bundles the IF/MEM pipeline request ports and the memctrl port around mem_arbiter.
// slave: the arbiter's view. master: the requesters plus memctrl.
interface mem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic        if_ack_o;
  logic [31:0] if_data_o;

  logic        mem_req_i;
  logic        mem_we_i;
  logic [1:0]  mem_size_i;
  logic        mem_sign_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        mem_ack_o;
  logic [31:0] mem_data_o;

  logic        mc_if_re_o;
  logic [31:0] mc_if_addr_o;
  logic [1:0]  mc_mem_re_o;
  logic        mc_mem_rsign_o;
  logic [31:0] mc_mem_addr_o;
  logic [1:0]  mc_mem_we_o;
  logic [31:0] mc_mem_wdata_o;
  logic        mc_done_i;
  logic [31:0] mc_data_i;

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_ack_o, if_data_o,
    input  mem_req_i, mem_we_i, mem_size_i, mem_sign_i, mem_addr_i, mem_wdata_i,
    output mem_ack_o, mem_data_o,
    output mc_if_re_o, mc_if_addr_o, mc_mem_re_o, mc_mem_rsign_o,
    output mc_mem_addr_o, mc_mem_we_o, mc_mem_wdata_o,
    input  mc_done_i, mc_data_i
  );

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_ack_o, if_data_o,
    output mem_req_i, mem_we_i, mem_size_i, mem_sign_i, mem_addr_i, mem_wdata_i,
    input  mem_ack_o, mem_data_o,
    input  mc_if_re_o, mc_if_addr_o, mc_mem_re_o, mc_mem_rsign_o,
    input  mc_mem_addr_o, mc_mem_we_o, mc_mem_wdata_o,
    output mc_done_i, mc_data_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single memctrl port between instruction fetch and load/store.
// MEM has priority; a saturating starvation counter forces IF through after STARVE_LIMIT MEM grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  mem_arbiter_if.slave   bus
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, BADACK} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_t;

  state_t           state_q, state_d;
  owner_t           owner_q, owner_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             flushed_q, flushed_d;
  logic [31:0]      hold_addr_q, hold_addr_d;
  logic             hold_we_q, hold_we_d;
  logic [1:0]       hold_size_q, hold_size_d;
  logic             hold_sign_q, hold_sign_d;
  logic [31:0]      hold_wdata_q, hold_wdata_d;

  logic if_pend;
  logic force_if;
  logic busy;
  logic drive;
  logic complete;
  logic own_if;
  logic own_mem;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign if_pend  = bus.if_req_i & ~bus.if_flush_i;
  assign force_if = if_pend & (starve_q == CNT_MAX);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_d     = starve_q;
    flushed_d    = flushed_q;
    hold_addr_d  = hold_addr_q;
    hold_we_d    = hold_we_q;
    hold_size_d  = hold_size_q;
    hold_sign_d  = hold_sign_q;
    hold_wdata_d = hold_wdata_q;

    case (state_q)
      IDLE: begin
        flushed_d = 1'b0;
        owner_d   = OWN_NONE;
        if (bus.mem_req_i && !force_if) begin
          owner_d      = OWN_MEM;
          hold_addr_d  = bus.mem_addr_i;
          hold_we_d    = bus.mem_we_i;
          hold_size_d  = bus.mem_size_i;
          hold_sign_d  = bus.mem_sign_i;
          hold_wdata_d = bus.mem_wdata_i;
          state_d      = (bus.mem_size_i == 2'b00) ? BADACK : ISSUE;
          starve_d     = if_pend ? sat_inc(starve_q) : '0;
        end else if (if_pend) begin
          owner_d      = OWN_IF;
          hold_addr_d  = bus.if_addr_i;
          hold_we_d    = 1'b0;
          hold_size_d  = 2'b00;
          hold_sign_d  = 1'b0;
          hold_wdata_d = '0;
          state_d      = ISSUE;
          starve_d     = '0;
        end else begin
          starve_d = '0;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        if (owner_q == OWN_IF && bus.if_flush_i) flushed_d = 1'b1;
      end
      WAIT: begin
        if (owner_q == OWN_IF && bus.if_flush_i) flushed_d = 1'b1;
        if (bus.mc_done_i) begin
          state_d   = IDLE;
          owner_d   = OWN_NONE;
          flushed_d = 1'b0;
        end
      end
      BADACK: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // rdy low freezes every register, so combinational acks repeat until it returns
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_NONE;
      starve_q     <= '0;
      flushed_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_we_q    <= 1'b0;
      hold_size_q  <= 2'b00;
      hold_sign_q  <= 1'b0;
      hold_wdata_q <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_q     <= starve_d;
      flushed_q    <= flushed_d;
      hold_addr_q  <= hold_addr_d;
      hold_we_q    <= hold_we_d;
      hold_size_q  <= hold_size_d;
      hold_sign_q  <= hold_sign_d;
      hold_wdata_q <= hold_wdata_d;
    end
  end

  // Strobes drop in the done cycle so memctrl never sees a second request; addr/wdata stay held
  assign busy     = (state_q == ISSUE) | (state_q == WAIT);
  assign drive    = (state_q == ISSUE) | ((state_q == WAIT) & ~bus.mc_done_i);
  assign complete = (state_q == WAIT) & bus.mc_done_i;
  assign own_if   = (owner_q == OWN_IF);
  assign own_mem  = (owner_q == OWN_MEM);

  always_comb begin
    bus.mc_if_re_o     = drive & own_if;
    bus.mc_if_addr_o   = (busy & own_if) ? hold_addr_q : 32'h0;
    bus.mc_mem_re_o    = (drive & own_mem & ~hold_we_q) ? hold_size_q : 2'b00;
    bus.mc_mem_we_o    = (drive & own_mem & hold_we_q) ? hold_size_q : 2'b00;
    bus.mc_mem_rsign_o = busy & own_mem & hold_sign_q;
    bus.mc_mem_addr_o  = (busy & own_mem) ? hold_addr_q : 32'h0;
    bus.mc_mem_wdata_o = (busy & own_mem) ? hold_wdata_q : 32'h0;

    bus.if_ack_o   = complete & own_if & ~flushed_q & ~bus.if_flush_i;
    bus.if_data_o  = bus.if_ack_o ? bus.mc_data_i : 32'h0;
    bus.mem_ack_o  = (complete & own_mem) | (state_q == BADACK);
    bus.mem_data_o = (complete & own_mem) ? bus.mc_data_i : 32'h0;
  end

endmodule
